spi_reg_slave: RTL and testbench



---
 rtl/spi_reg_slave.sv | 185 ++++++++++++++++++
 tb/tb_spi_reg_slave.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/spi_reg_slave.sv
// SPI register-access responder: decodes 24-bit R/W frames on oversampled pins
// and reads or writes a bank of 16-bit configuration registers.
module spi_reg_slave #(
  parameter int unsigned p_num_regs    = 8,
  parameter bit          p_cpol        = 1'b0,
  parameter logic [15:0] p_reset_value = '0
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       i_sclk,
  input  logic                       i_cs_n,
  input  logic                       i_mosi,
  output logic                       or_miso,
  output logic [16*p_num_regs-1:0]   op_regs,
  output logic                       o_wr_valid,
  output logic [6:0]                 o_wr_addr,
  output logic [15:0]                o_wr_data,
  output logic                       o_err,
  output logic                       o_busy
);

  typedef enum logic [2:0] {IDLE, CMD, DATA, COMMIT, WAIT_CS} state_t;

  state_t      state_q, state_d;
  logic [2:0]  sclk_sync_q, cs_sync_q;
  logic [1:0]  mosi_sync_q;
  logic [4:0]  cnt_q, cnt_d;
  logic [23:0] rx_q, rx_d;
  logic [15:0] tx_q, tx_d;
  logic        rw_q, rw_d;
  logic [6:0]  addr_q, addr_d;
  logic        miso_q, miso_d;
  logic        wr_valid_q, wr_valid_d;
  logic [6:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic [15:0] regs_q [p_num_regs];
  logic [15:0] regs_d [p_num_regs];

  logic sck_rise, sck_fall, sample_edge, shift_edge, cs_high, cs_fall;
  logic [15:0] rd_val;
  logic        cmd_in_range, addr_in_range;

  assign sck_rise    = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sck_fall    = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign sample_edge = p_cpol ? sck_fall : sck_rise;
  assign shift_edge  = p_cpol ? sck_rise : sck_fall;
  assign cs_high     = cs_sync_q[1];
  assign cs_fall     = ~cs_sync_q[1] & cs_sync_q[2];

  // cs_n sync resets low so a select already asserted at reset release is
  // not seen as a fresh fall; it must rise (and fall again) first.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sclk_sync_q <= {3{p_cpol}};
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      miso_q      <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      for (int unsigned i = 0; i < p_num_regs; i++) regs_q[i] <= p_reset_value;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], i_sclk};
      cs_sync_q   <= {cs_sync_q[1:0], i_cs_n};
      mosi_sync_q <= {mosi_sync_q[0], i_mosi};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      miso_q      <= miso_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      for (int unsigned i = 0; i < p_num_regs; i++) regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    miso_d     = miso_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    err_d      = 1'b0;
    regs_d     = regs_q;
    rd_val     = '0;

    if (sample_edge) rx_d = {rx_q[22:0], mosi_sync_q[1]};
    cmd_in_range  = 32'(rx_d[6:0]) < p_num_regs;
    addr_in_range = 32'(addr_q) < p_num_regs;
    for (int unsigned i = 0; i < p_num_regs; i++)
      if (rx_d[6:0] == 7'(i)) rd_val = regs_q[i];

    unique case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        cnt_d  = '0;
        rx_d   = rx_q;
        if (cs_fall) state_d = CMD;
      end
      CMD: begin
        if (cs_high) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (sample_edge) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            rw_d    = rx_d[7];
            addr_d  = rx_d[6:0];
            tx_d    = (rx_d[7] && cmd_in_range) ? rd_val : '0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (cs_high) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          if (shift_edge) begin
            miso_d = tx_q[15];
            tx_d   = {tx_q[14:0], 1'b0};
          end
          if (sample_edge) begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd23) state_d = COMMIT;
          end
        end
      end
      COMMIT: begin
        rx_d = rx_q;
        if (!addr_in_range) begin
          err_d = 1'b1;
        end else if (!rw_q) begin
          wr_valid_d = 1'b1;
          wr_addr_d  = addr_q;
          wr_data_d  = rx_q[15:0];
          for (int unsigned i = 0; i < p_num_regs; i++)
            if (addr_q == 7'(i)) regs_d[i] = rx_q[15:0];
        end
        state_d = WAIT_CS;
      end
      WAIT_CS: begin
        rx_d = rx_q;
        if (cs_high) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (cs_high) miso_d = 1'b0;
    busy_d = (state_d != IDLE);
  end

  always_comb begin
    op_regs = '0;
    for (int unsigned i = 0; i < p_num_regs; i++) op_regs[16*i +: 16] = regs_q[i];
  end

  assign or_miso    = miso_q;
  assign o_wr_valid = wr_valid_q;
  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = wr_data_q;
  assign o_err      = err_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Randomized bench for spi_reg_slave: bit-banged SPI mode-0 master plus a
// frame-level shadow model of the register bank.
module tb_spi_reg_slave;
  localparam int unsigned NREG = 8;
  localparam logic [15:0] RST  = 16'h1234;
  localparam int unsigned HALF = 5;

  logic clk = 1'b0;
  logic resetn, sclk, cs_n, mosi;
  logic miso, wr_valid, err, busy;
  logic [16*NREG-1:0] regs;
  logic [6:0]  wr_addr;
  logic [15:0] wr_data;

  int checks = 0, failures = 0;
  int wr_cnt = 0, err_cnt = 0;
  logic [6:0]  seen_addr;
  logic [15:0] seen_data, seen_reg;
  logic [15:0] model [NREG];

  spi_reg_slave #(.p_num_regs(NREG), .p_cpol(1'b0), .p_reset_value(RST)) dut (
    .clk(clk), .resetn(resetn), .i_sclk(sclk), .i_cs_n(cs_n), .i_mosi(mosi),
    .or_miso(miso), .op_regs(regs), .o_wr_valid(wr_valid), .o_wr_addr(wr_addr),
    .o_wr_data(wr_data), .o_err(err), .o_busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (resetn) begin
      if (wr_valid) begin
        wr_cnt++;
        seen_addr = wr_addr;
        seen_data = wr_data;
        seen_reg  = (wr_addr < 7'(NREG)) ? regs[16*wr_addr +: 16] : 16'hxxxx;
      end
      if (err) err_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] flat();
    logic [127:0] r = '0;
    for (int i = 0; i < int'(NREG); i++) r[16*i +: 16] = model[i];
    return r;
  endfunction

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Clocks n bits of f (MSB first) with cs_n already low; captures MISO before
  // each rising edge of bits 8..23.
  task automatic bits(input logic [23:0] f, input int unsigned n, output logic [15:0] rd);
    rd = '0;
    for (int unsigned i = 0; i < n; i++) begin
      mosi = (i < 24) ? f[23-i] : 1'b0;
      wait_clk(HALF);
      if (i >= 8 && i < 24) rd = {rd[14:0], miso};
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic xfer(input logic [23:0] f, input int unsigned n, output logic [15:0] rd);
    cs_n = 1'b0;
    wait_clk(HALF);
    bits(f, n, rd);
    wait_clk(HALF);
    cs_n = 1'b1;
    wait_clk(2*HALF);
  endtask

  task automatic run_frame(input logic [23:0] f, input int unsigned extra);
    int w0, e0, exp_wr;
    logic [15:0] rd;
    logic [6:0] a;
    logic inr;
    w0 = wr_cnt; e0 = err_cnt;
    xfer(f, 24 + extra, rd);
    a = f[22:16];
    inr = a < 7'(NREG);
    exp_wr = (!f[23] && inr) ? 1 : 0;
    if (exp_wr == 1) model[a[2:0]] = f[15:0];
    chk("wr_pulses", 128'(wr_cnt - w0), 128'(exp_wr));
    chk("err_pulses", 128'(err_cnt - e0), inr ? 128'd0 : 128'd1);
    if (exp_wr == 1) begin
      chk("wr_addr", 128'(seen_addr), 128'(a));
      chk("wr_data", 128'(seen_data), 128'(f[15:0]));
      chk("reg_at_pulse", 128'(seen_reg), 128'(f[15:0]));
    end
    if (f[23]) chk("rd_data", 128'(rd), inr ? 128'(model[a[2:0]]) : 128'd0);
    chk("regs", regs, flat());
    chk("busy_idle", 128'(busy), 128'd0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_miso", 128'(miso), 128'd0);
    chk("rst_wr_valid", 128'(wr_valid), 128'd0);
    chk("rst_err", 128'(err), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_wr_addr", 128'(wr_addr), 128'd0);
    chk("rst_wr_data", 128'(wr_data), 128'd0);
    chk("rst_regs", regs, flat());
  endtask

  initial begin
    logic [15:0] rd;
    logic [6:0]  a;
    logic [15:0] d;
    int w0, e0;

    resetn = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    for (int i = 0; i < int'(NREG); i++) model[i] = RST;
    wait_clk(4);
    chk_reset_outputs();
    resetn = 1'b1;
    wait_clk(6);

    for (int i = 0; i < int'(NREG); i++) run_frame({1'b1, 7'(i), 16'h0000}, 0);

    run_frame(24'h03ABCD, 0);
    chk("reg3_slice", 128'(regs[63:48]), 128'hABCD);
    run_frame(24'h830000, 0);

    run_frame(24'h0A5555, 0);
    run_frame(24'h8A0000, 0);
    run_frame(24'hFF0000, 0);

    w0 = wr_cnt; e0 = err_cnt;
    xfer(24'h05FFFF, 12, rd);
    chk("abort_err", 128'(err_cnt - e0), 128'd1);
    chk("abort_wr", 128'(wr_cnt - w0), 128'd0);
    chk("abort_reg5", 128'(regs[95:80]), 128'(model[5]));
    run_frame(24'h05BEEF, 0);
    run_frame(24'h850000, 0);

    w0 = wr_cnt; e0 = err_cnt;
    cs_n = 1'b0;
    wait_clk(HALF);
    bits(24'h027777, 20, rd);
    wait_clk(2);
    resetn = 1'b0;
    for (int i = 0; i < int'(NREG); i++) model[i] = RST;
    wait_clk(3);
    chk_reset_outputs();
    resetn = 1'b1;
    wait_clk(HALF);
    bits(24'h02AAAA, 24, rd);
    wait_clk(HALF);
    chk("cs_low_at_release_busy", 128'(busy), 128'd0);
    cs_n = 1'b1;
    wait_clk(2*HALF);
    chk("midreset_wr", 128'(wr_cnt - w0), 128'd0);
    chk("midreset_err", 128'(err_cnt - e0), 128'd0);
    chk("midreset_regs", regs, flat());
    run_frame(24'h820000, 0);

    for (int n = 0; n < 100; n++) begin
      a = (($urandom_range(0, 9) == 0) ? 7'($urandom_range(8, 127)) : 7'($urandom_range(0, NREG-1)));
      d = 16'($urandom);
      run_frame({1'b0, a, d}, $urandom_range(0, 3));
      run_frame({1'b1, a, 16'($urandom)}, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
